// File: rtl/regfile_sb_pkg.sv
// Shared types and default constants for the scoreboarded register file.
package regfile_pkg;

  localparam int DATA_W    = 64;
  localparam int ADDR_W    = 5;
  localparam int NUM_RD    = 2;
  localparam int ZERO_REG  = 31;
  localparam int DEBUG_REG = 24;

  typedef enum logic {
    INIT,
    RUN
  } rfState_e;

endpackage

// File: rtl/regfile_sb_if.sv
// Decode/writeback side bus of the register file: reads, writeback, issue, status.
interface regfile_sb_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W,
  parameter int NUM_RD = regfile_pkg::NUM_RD
);

  logic [NUM_RD*ADDR_W-1:0] rdAddr;
  logic [NUM_RD*DATA_W-1:0] rdData;
  logic [NUM_RD-1:0]        rdBusy;
  logic                     wrEn;
  logic [ADDR_W-1:0]        wrAddr;
  logic [DATA_W-1:0]        wrData;
  logic                     issEn;
  logic [ADDR_W-1:0]        issAddr;
  logic                     ready;
  logic [DATA_W-1:0]        debugData;

  modport master (
    output rdAddr, wrEn, wrAddr, wrData, issEn, issAddr,
    input  rdData, rdBusy, ready, debugData
  );

  modport slave (
    input  rdAddr, wrEn, wrAddr, wrData, issEn, issAddr,
    output rdData, rdBusy, ready, debugData
  );

endinterface

// File: rtl/regfile_sb_scoreboard.sv
// One busy bit per register: issue sets, writeback clears, issue wins on a tie.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = regfile_pkg::ADDR_W,
  parameter int NUM_RD   = regfile_pkg::NUM_RD,
  parameter int ZERO_REG = regfile_pkg::ZERO_REG
)(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     wrEn,
  input  logic [ADDR_W-1:0]        wrAddr,
  input  logic                     issEn,
  input  logic [ADDR_W-1:0]        issAddr,
  input  logic [NUM_RD*ADDR_W-1:0] lookAddr,
  output logic [NUM_RD-1:0]        lookBusy
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_REG);

  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] nextBusy;

  // Set is applied after clear so a same-edge reissue leaves the new producer pending.
  always_comb begin
    nextBusy = busy;
    if (wrEn) begin
      nextBusy[wrAddr] = 1'b0;
    end
    if (issEn && issAddr != ZERO_A) begin
      nextBusy[issAddr] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else if (en) begin
      busy <= nextBusy;
    end
  end

  always_comb begin
    lookBusy = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      lookBusy[i] = busy[lookAddr[i*ADDR_W +: ADDR_W]];
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Register file with write-to-read bypass, zero register, debug tap and busy
// scoreboard; clears itself one entry per cycle after reset before raising ready.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W    = regfile_pkg::DATA_W,
  parameter int ADDR_W    = regfile_pkg::ADDR_W,
  parameter int NUM_RD    = regfile_pkg::NUM_RD,
  parameter int ZERO_REG  = regfile_pkg::ZERO_REG,
  parameter int DEBUG_REG = regfile_pkg::DEBUG_REG
)(
  input logic         clk,
  input logic         rst,
  regfile_sb_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ONE_A   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ZERO_A  = ADDR_W'(ZERO_REG);
  localparam logic [ADDR_W-1:0] DEBUG_A = ADDR_W'(DEBUG_REG);

  rfState_e          state;
  rfState_e          nextState;
  logic              run;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [NUM_RD-1:0] sbBusy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= INIT;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    if (state == INIT && cnt == LAST_A) begin
      nextState = RUN;
    end
  end

  always_comb begin
    run       = (state == RUN);
    bus.ready = run;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (state == INIT) begin
      cnt <= cnt + ONE_A;
    end
  end

  // The array itself has no reset; the INIT sweep is what defines its contents.
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      mem[cnt] <= '0;
    end else if (bus.wrEn && bus.wrAddr != ZERO_A) begin
      mem[bus.wrAddr] <= bus.wrData;
    end
  end

  rf_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NUM_RD   (NUM_RD),
    .ZERO_REG (ZERO_REG)
  ) uScoreboard (
    .clk      (clk),
    .rst      (rst),
    .en       (run),
    .wrEn     (bus.wrEn),
    .wrAddr   (bus.wrAddr),
    .issEn    (bus.issEn),
    .issAddr  (bus.issAddr),
    .lookAddr (bus.rdAddr),
    .lookBusy (sbBusy)
  );

  // A matching writeback forwards its data and retires the producer in the same cycle.
  always_comb begin
    bus.rdData = '0;
    bus.rdBusy = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      if (run && bus.rdAddr[i*ADDR_W +: ADDR_W] != ZERO_A) begin
        if (bus.wrEn && bus.wrAddr == bus.rdAddr[i*ADDR_W +: ADDR_W]) begin
          bus.rdData[i*DATA_W +: DATA_W] = bus.wrData;
        end else begin
          bus.rdData[i*DATA_W +: DATA_W] = mem[bus.rdAddr[i*ADDR_W +: ADDR_W]];
          bus.rdBusy[i]                  = sbBusy[i];
        end
      end
    end
  end

  assign bus.debugData = run ? mem[DEBUG_A] : '0;

endmodule
